// File: rtl/pgm_pkg.sv
// Shared definitions for the push-button input controller: FSM states,
// command codes on MORE and the default debounce length.
package pgm_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } pgm_state_t;

    typedef enum logic [1:0] {
        MORE_STAND = 2'b00,
        MORE_HIT_A = 2'b01,
        MORE_HIT_B = 2'b10,
        MORE_DEAL  = 2'b11
    } more_cmd_t;

endpackage

// File: rtl/pgm_sync2.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous reset.
module pgm_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pgm_input_ctrl.sv
// Debounced push-button front end: one strobe per accepted press, latching
// the command switches and counting presses.
//
// state         | meaning
// ST_IDLE       | button released and stable
// ST_PRESS_DB   | button seen pressed, counting stable cycles
// ST_HELD       | press accepted, waiting for release
// ST_RELEASE_DB | button seen released, counting stable cycles
module pgm_input_ctrl
    import pgm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_RAW,
    input  logic [1:0] SW_MORE,
    output logic       IN_VALID,
    output logic       BUTTON,
    output logic [1:0] MORE,
    output logic [7:0] PRESS_CNT
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    pgm_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic          btn_s;
    logic [1:0]    more_s;

    pgm_sync2 #(.WIDTH(3)) u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     ({SW_MORE, BTN_RAW}),
        .q     ({more_s, btn_s})
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (btn_s) begin
                    state_nxt = ST_PRESS_DB;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!btn_s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                    accept    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_nxt = ST_RELEASE_DB;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt = '0;
                end
            end
            ST_RELEASE_DB: begin
                // A bounce back to pressed re-enters HELD silently: no auto-repeat.
                if (btn_s) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            IN_VALID  <= 1'b0;
            BUTTON    <= 1'b0;
            MORE      <= MORE_STAND;
            PRESS_CNT <= '0;
        end else begin
            IN_VALID <= accept;
            BUTTON   <= accept;
            if (accept) begin
                MORE      <= more_s;
                PRESS_CNT <= PRESS_CNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pgm_input_ctrl.sv
// Self-checking bench for pgm_input_ctrl: strobe timing, latched command,
// press count, bounce rejection and reset cancellation.
module tb_pgm_input_ctrl;
    import pgm_pkg::*;

    localparam int D = 16;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       BTN_RAW;
    logic [1:0] SW_MORE;
    logic       IN_VALID;
    logic       BUTTON;
    logic [1:0] MORE;
    logic [7:0] PRESS_CNT;

    pgm_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .BTN_RAW   (BTN_RAW),
        .SW_MORE   (SW_MORE),
        .IN_VALID  (IN_VALID),
        .BUTTON    (BUTTON),
        .MORE      (MORE),
        .PRESS_CNT (PRESS_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] more;
        logic [7:0] cnt;
        int         edge_no;
    } exp_t;

    typedef struct {
        logic [1:0] sw;
        int         high;
        int         low;
        bit         strobe;
    } vec_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         strobe_total = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic       prev_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Expected strobe edge: first sampling edge is cyc+1, strobe D+1 edges later.
    task automatic push_exp(input logic [1:0] sw);
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back(exp_t'{more: sw, cnt: exp_cnt, edge_no: cyc + D + 2});
    endtask

    task automatic press(input logic [1:0] sw, input int high, input int low, input bit exp_strobe);
        SW_MORE = sw;
        BTN_RAW = 1'b1;
        if (exp_strobe) push_exp(sw);
        cycles(high);
        BTN_RAW = 1'b0;
        cycles(low);
        chk("drained", sb.size(), 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (IN_VALID || BUTTON) begin
            strobe_total++;
            chk("button_eq_valid", int'(BUTTON), int'(IN_VALID));
            chk("strobe_width", int'(prev_valid), 0);
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: strobe at edge %0d, none expected", cyc);
            end else begin
                e = sb.pop_front();
                chk("strobe_edge", cyc, e.edge_no);
                chk("more", int'(MORE), int'(e.more));
                chk("press_cnt", int'(PRESS_CNT), int'(e.cnt));
            end
        end
        prev_valid = IN_VALID;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{sw: MORE_HIT_B, high: D,      low: 24, strobe: 1'b1};
        vecs[1] = '{sw: MORE_DEAL,  high: D - 1,  low: 24, strobe: 1'b0};
        vecs[2] = '{sw: MORE_STAND, high: 40,     low: 24, strobe: 1'b1};
        vecs[3] = '{sw: MORE_HIT_A, high: 1,      low: 5,  strobe: 1'b0};
        vecs[4] = '{sw: MORE_DEAL,  high: 20,     low: 24, strobe: 1'b1};
        vecs[5] = '{sw: MORE_HIT_A, high: D + 1,  low: 30, strobe: 1'b1};

        RESET   = 1'b1;
        BTN_RAW = 1'b0;
        SW_MORE = 2'b00;
        cycles(3);
        chk("rst_in_valid", int'(IN_VALID), 0);
        chk("rst_button", int'(BUTTON), 0);
        chk("rst_more", int'(MORE), 0);
        chk("rst_press_cnt", int'(PRESS_CNT), 0);
        RESET = 1'b0;
        cycles(5);

        // Clean press with HIT_A selected
        press(MORE_HIT_A, 30, 30, 1'b1);

        for (int i = 0; i < 6; i++)
            press(vecs[i].sw, vecs[i].high, vecs[i].low, vecs[i].strobe);

        // Bounce 5 high / 3 low for 40 cycles, then held
        SW_MORE = MORE_STAND;
        repeat (5) begin
            BTN_RAW = 1'b1;
            cycles(5);
            BTN_RAW = 1'b0;
            cycles(3);
        end
        BTN_RAW = 1'b1;
        push_exp(MORE_STAND);
        cycles(30);
        BTN_RAW = 1'b0;
        cycles(30);
        chk("bounce_drained", sb.size(), 0);

        // Long hold with a switch change mid-hold
        SW_MORE = MORE_HIT_B;
        BTN_RAW = 1'b1;
        push_exp(MORE_HIT_B);
        cycles(100);
        SW_MORE = MORE_DEAL;
        cycles(100);
        BTN_RAW = 1'b0;
        cycles(30);
        chk("hold_more_kept", int'(MORE), int'(MORE_HIT_B));
        chk("hold_drained", sb.size(), 0);

        // Release glitch in HELD and a short release/re-press
        SW_MORE = MORE_HIT_A;
        BTN_RAW = 1'b1;
        push_exp(MORE_HIT_A);
        cycles(30);
        BTN_RAW = 1'b0;
        cycles(1);
        BTN_RAW = 1'b1;
        cycles(20);
        BTN_RAW = 1'b0;
        cycles(4);
        BTN_RAW = 1'b1;
        cycles(20);
        BTN_RAW = 1'b0;
        cycles(30);
        chk("glitch_drained", sb.size(), 0);

        // Reset during PRESS_DB with counter at 10
        SW_MORE = MORE_DEAL;
        BTN_RAW = 1'b1;
        cycles(12);
        RESET   = 1'b1;
        BTN_RAW = 1'b0;
        cycles(1);
        RESET   = 1'b0;
        exp_cnt = 8'd0;
        chk("midrst_in_valid", int'(IN_VALID), 0);
        chk("midrst_button", int'(BUTTON), 0);
        chk("midrst_more", int'(MORE), 0);
        chk("midrst_press_cnt", int'(PRESS_CNT), 0);
        cycles(20);
        press(MORE_DEAL, 30, 30, 1'b1);

        // Reset landing on the strobe edge cancels it
        SW_MORE = MORE_HIT_B;
        BTN_RAW = 1'b1;
        cycles(D + 1);
        RESET   = 1'b1;
        BTN_RAW = 1'b0;
        cycles(1);
        RESET   = 1'b0;
        exp_cnt = 8'd0;
        chk("strobe_rst_in_valid", int'(IN_VALID), 0);
        chk("strobe_rst_press_cnt", int'(PRESS_CNT), 0);
        cycles(25);
        chk("strobe_rst_drained", sb.size(), 0);

        // Reset while held: a full debounce is needed after release of reset
        SW_MORE = MORE_HIT_A;
        BTN_RAW = 1'b1;
        push_exp(MORE_HIT_A);
        cycles(30);
        RESET = 1'b1;
        cycles(3);
        RESET   = 1'b0;
        exp_cnt = 8'd0;
        push_exp(MORE_HIT_A);
        cycles(30);
        BTN_RAW = 1'b0;
        cycles(30);
        chk("held_rst_drained", sb.size(), 0);

        // 256 presses wrap the counter back to zero
        RESET = 1'b1;
        cycles(2);
        RESET   = 1'b0;
        exp_cnt = 8'd0;
        cycles(2);
        begin
            int base;
            base = strobe_total;
            for (int i = 0; i < 256; i++)
                press(2'(i % 4), 18, 22, 1'b1);
            chk("wrap_press_cnt", int'(PRESS_CNT), 0);
            chk("wrap_strobes", strobe_total - base, 256);
        end

        cycles(5);
        chk("final_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pgm_input_ctrl.md
PGM_INPUT_CTRL -- requirements
Module: pgm_input_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the consecutive stable cycles required to accept a press or a release; legal range 2..65535.
REQ-002 The block SHALL have port CLK, input, 1, the single clock.
REQ-003 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port BTN_RAW, input, 1, asynchronous bouncy push-button level, 1 = pressed.
REQ-005 The block SHALL have port SW_MORE, input, 2, asynchronous command switches.
REQ-006 The block SHALL have port IN_VALID, output, 1, one-cycle command strobe to the game core.
REQ-007 The block SHALL have port BUTTON, output, 1, one-cycle press strobe, coincident with IN_VALID.
REQ-008 The block SHALL have port MORE, output, 2, command latched at press acceptance: 00 stand, 01 card to A, 10 card to B, 11 new deal.
REQ-009 The block SHALL have port PRESS_CNT, output, 8, count of accepted presses.

Function
REQ-010 BTN_RAW and both SW_MORE bits SHALL each pass through a two-flop synchronizer; the FSM SHALL use only the synchronized values (btn_s, more_s).
REQ-011 The FSM SHALL have states IDLE, PRESS_DB, HELD and RELEASE_DB, with one debounce counter sized for DEBOUNCE_CYCLES-1.
REQ-012 In IDLE, btn_s=1 SHALL move the FSM to PRESS_DB with counter=1; btn_s=0 SHALL keep it in IDLE.
REQ-013 In PRESS_DB, btn_s=0 SHALL return the FSM to IDLE with counter=0.
REQ-014 In PRESS_DB, btn_s=1 with counter<DEBOUNCE_CYCLES-1 SHALL increment the counter.
REQ-015 In PRESS_DB, btn_s=1 with counter=DEBOUNCE_CYCLES-1 SHALL accept the press and move the FSM to HELD.
REQ-016 On acceptance, IN_VALID and BUTTON SHALL be registered high for exactly one cycle, MORE SHALL load more_s, and PRESS_CNT SHALL increment.
REQ-017 Latency: with BTN_RAW first sampled 1 at edge k and held stable, IN_VALID SHALL rise at edge k+DEBOUNCE_CYCLES+1 (edge k+17 at default).
REQ-018 In HELD, btn_s=0 SHALL move the FSM to RELEASE_DB with counter=1; holding the button SHALL NOT produce further strobes (no auto-repeat).
REQ-019 In RELEASE_DB, btn_s=1 SHALL return the FSM to HELD without a new strobe.
REQ-020 In RELEASE_DB, DEBOUNCE_CYCLES consecutive cycles of btn_s=0 SHALL return the FSM to IDLE.
REQ-021 MORE SHALL hold its value between strobes; SW_MORE changes outside acceptance SHALL NOT affect MORE.
REQ-022 PRESS_CNT SHALL wrap from 255 to 0 with no flag.
REQ-023 A bounce shorter than DEBOUNCE_CYCLES in any debounce state SHALL produce no strobe and no count change.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-025 While RESET=1 at a clock edge, the block SHALL force state=IDLE, counter=0, synchronizer flops=0, IN_VALID=0, BUTTON=0, MORE=00 and PRESS_CNT=0.
REQ-026 A reset asserted mid-debounce or mid-strobe SHALL cancel any pending or active strobe in the same edge.
REQ-027 After reset release with the button held, one full press debounce SHALL be required before any strobe.

Structure
REQ-028 Shared package pgm_pkg SHALL hold the FSM state encodings, the MORE command codes (STAND=00, HIT_A=01, HIT_B=10, DEAL=11) and the default DEBOUNCE_CYCLES constant.
REQ-029 The two-flop synchronizer SHALL be a sub-module, pgm_sync2, parameterized by width and instantiated once at width 3.

Verification
REQ-030 Clean press: SW_MORE=01, BTN_RAW held 1 from edge 10 -> single IN_VALID/BUTTON pulse at edge 27, MORE=01, PRESS_CNT=1.
REQ-031 Bounce: BTN_RAW toggles with 5 cycles high / 3 low for 40 cycles, then held 1 -> exactly one strobe, 17 edges after the final rising sample.
REQ-032 Long hold plus switch change: button held 200 cycles, SW_MORE changes 10->11 during the hold -> one strobe only, MORE keeps the value latched at acceptance.
REQ-033 Reset mid-operation: RESET pulsed in PRESS_DB at counter=10 -> no strobe; outputs 0/00/0; a new full press strobes 17 edges after the next rising sample.
REQ-034 Wrap: 256 clean presses -> PRESS_CNT returns to 0; each press gives exactly one strobe.
REQ-035 Release glitch: 1-cycle drop of BTN_RAW during HELD, then re-press after a 4-cycle release -> no extra strobe for either.
